riscv32ima_wback: RTL and testbench

- Writeback/retire stage directly downstream of riscv32ima_lsu.
- Consumes the LSU result stream (lsu_valid/lsu_ready/opcode/reg_addr/data) and commits results into the 32x32 integer register file.
- Provides two combinational read ports for decode, with same-cycle write-through bypass.
- Drives the wback_reg_* forwarding bus back to the LSU.
- Maintains 64-bit cycle and instret counters, and a debug halt handshake.

---
 rtl/riscv32ima_wback.sv | 180 ++++++++++++++++++
 tb/tb_riscv32ima_wback.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv32ima_wback.sv
`default_nettype none
// ============================================================================
//  Module   : riscv32ima_wback
//  Purpose  : Writeback/retire stage behind riscv32ima_lsu. Commits LSU
//             results into the 32x32 integer register file, serves two
//             combinational read ports (with same-cycle write-through
//             bypass), drives the registered forwarding bus back to the LSU,
//             keeps 64-bit cycle/instret counters and a debug halt handshake.
//  Ports    : clk, nrst (sync, active-low)
//             lsu_valid/lsu_ready/lsu_opcode/lsu_reg_addr/lsu_data : result in
//             rs1_addr/rs1_data, rs2_addr/rs2_data : decode read ports
//             wback_reg_wen/addr/data : registered forwarding bus
//             halt_req/halted : debug halt handshake
//             cycle_cnt/instret_cnt : performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module riscv32ima_wback #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int OPCODE_WIDTH   = 7,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [OPCODE_WIDTH-1:0]   lsu_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_reg_addr,
  input  logic [REG_DATA_WIDTH-1:0] lsu_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_DATA_WIDTH-1:0] rs1_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [REG_DATA_WIDTH-1:0] rs2_data,
  output logic                      wback_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] wback_reg_data,
  input  logic                      halt_req,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      instret_cnt
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  // Opcodes whose result is committed to rd.
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_AMO    = 7'b0101111;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] c_OPC_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_accept;
  logic                      w_writes_rd;
  logic                      w_do_write;
  logic [REG_DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // --------------------------------------------------------------------------
  // Halt state machine. lsu_ready is a pure function of state so the LSU can
  // never see a combinational path from its own valid back to ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    lsu_ready    = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_RUN: begin
        lsu_ready = 1'b1;
        if (halt_req) w_state_next = ST_HALT;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // Accept / commit decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_writes_rd = 1'b0;
    case (lsu_opcode)
      c_OPC_LOAD, c_OPC_OP_IMM, c_OPC_AUIPC, c_OPC_OP, c_OPC_LUI,
      c_OPC_AMO, c_OPC_JALR, c_OPC_JAL, c_OPC_SYSTEM: w_writes_rd = 1'b1;
      default:                                        w_writes_rd = 1'b0;
    endcase
  end

  assign w_accept   = lsu_valid & lsu_ready;
  assign w_do_write = w_accept & w_writes_rd & (lsu_reg_addr != '0);

  // --------------------------------------------------------------------------
  // Register file. Entry 0 is reset and never written, so it stays zero; the
  // read ports still force zero explicitly for x0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_do_write) begin
      r_regs[lsu_reg_addr] <= lsu_data;
    end
  end

  // Read ports with write-through bypass so decode sees a result in the same
  // cycle it retires.
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (w_do_write && (lsu_reg_addr == rs1_addr)) begin
      rs1_data = lsu_data;
    end
  end

  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (w_do_write && (lsu_reg_addr == rs2_addr)) begin
      rs2_data = lsu_data;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding bus: wen pulses for one cycle per write; addr/data capture
  // every accept (including non-writing ones) and otherwise hold.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wback_reg_wen  <= 1'b0;
      wback_reg_addr <= '0;
      wback_reg_data <= '0;
    end else begin
      wback_reg_wen <= w_do_write;
      if (w_accept) begin
        wback_reg_addr <= lsu_reg_addr;
        wback_reg_data <= lsu_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters, free-running and wrapping.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (w_accept) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv32ima_wback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv32ima_wback
//  Purpose  : Self-checking bench for riscv32ima_wback: directed scenarios
//             followed by randomized traffic compared against a behavioural
//             model of the retire stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv32ima_wback;

  logic        clk;
  logic        nrst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [6:0]  lsu_opcode;
  logic [4:0]  lsu_reg_addr;
  logic [31:0] lsu_data;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        wback_reg_wen;
  logic [4:0]  wback_reg_addr;
  logic [31:0] wback_reg_data;
  logic        halt_req;
  logic        halted;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  riscv32ima_wback dut (
    .clk           (clk),
    .nrst          (nrst),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_opcode    (lsu_opcode),
    .lsu_reg_addr  (lsu_reg_addr),
    .lsu_data      (lsu_data),
    .rs1_addr      (rs1_addr),
    .rs1_data      (rs1_data),
    .rs2_addr      (rs2_addr),
    .rs2_data      (rs2_data),
    .wback_reg_wen (wback_reg_wen),
    .wback_reg_addr(wback_reg_addr),
    .wback_reg_data(wback_reg_data),
    .halt_req      (halt_req),
    .halted        (halted),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 0;
  logic [31:0] m_regs [32];
  bit          m_halted;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  function automatic bit is_writer(input logic [6:0] op);
    return op inside {OP_LOAD, OP_OPIMM, OP_AUIPC, OP_OP, OP_LUI,
                      OP_AMO, OP_JALR, OP_JAL, OP_SYSTEM};
  endfunction

  function automatic bit m_accept();
    return lsu_valid && !m_halted;
  endfunction

  function automatic bit m_dowrite();
    return m_accept() && is_writer(lsu_opcode) && (lsu_reg_addr != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_dowrite() && lsu_reg_addr == a) return lsu_data;
    return m_regs[a];
  endfunction

  // Applied at each rising edge with the inputs that were stable there.
  task automatic model_edge();
    if (!nrst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_halted  = 0;
      m_wen     = 0;
      m_addr    = 5'd0;
      m_data    = 32'd0;
      m_cycle   = 64'd0;
      m_instret = 64'd0;
      m_known   = 1;
    end else if (m_known) begin
      bit acc, dw;
      acc = m_accept();
      dw  = m_dowrite();
      m_wen = dw;
      if (acc) begin
        m_addr = lsu_reg_addr;
        m_data = lsu_data;
        m_instret = m_instret + 64'd1;
      end
      if (dw) m_regs[lsu_reg_addr] = lsu_data;
      m_cycle = m_cycle + 64'd1;
      // The halt handshake simply tracks halt_req one cycle later.
      m_halted = halt_req;
    end
  endtask

  task automatic check_all();
    if (m_known) begin
      chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, !m_halted});
      chk("halted",    {63'd0, halted},    {63'd0, m_halted});
      chk("rs1_data",  {32'd0, rs1_data},  {32'd0, m_read(rs1_addr)});
      chk("rs2_data",  {32'd0, rs2_data},  {32'd0, m_read(rs2_addr)});
      chk("wb_wen",    {63'd0, wback_reg_wen}, {63'd0, m_wen});
      chk("wb_addr",   {59'd0, wback_reg_addr}, {59'd0, m_addr});
      chk("wb_data",   {32'd0, wback_reg_data}, {32'd0, m_data});
      chk("cycle_cnt", cycle_cnt, m_cycle);
      chk("instret",   instret_cnt, m_instret);
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit
  // later, then the model advances on the rising edge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [31:0] d);
    lsu_valid    = v;
    lsu_opcode   = op;
    lsu_reg_addr = rd;
    lsu_data     = d;
  endtask

  logic [6:0]  op_tbl [12];
  logic [63:0] inst0;

  initial begin
    op_tbl = '{OP_LOAD, OP_OPIMM, OP_AUIPC, OP_OP, OP_LUI, OP_AMO,
               OP_JALR, OP_JAL, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_MISC};
    nrst = 1'b0; halt_req = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    drive(0, OP_OP, 5'd0, 32'd0);
    @(negedge clk);
    tick(); tick();

    // Idle after reset.
    nrst = 1'b1; rs1_addr = 5'd5;
    repeat (10) tick();
    #1;
    chk("idle_cycle", cycle_cnt, 64'd10);
    chk("idle_instret", instret_cnt, 64'd0);
    chk("idle_rs1", {32'd0, rs1_data}, 64'd0);

    // OP rd=3 with same-cycle bypass.
    drive(1, OP_OP, 5'd3, 32'hDEADBEEF); rs1_addr = 5'd3;
    #1 chk("bypass_rs1", {32'd0, rs1_data}, 64'hDEADBEEF);
    tick();
    drive(0, OP_OP, 5'd0, 32'd0);
    #1;
    chk("op_wen", {63'd0, wback_reg_wen}, 64'd1);
    chk("op_addr", {59'd0, wback_reg_addr}, 64'd3);
    chk("op_data", {32'd0, wback_reg_data}, 64'hDEADBEEF);
    chk("op_instret", instret_cnt, 64'd1);
    tick();
    #1;
    chk("op_wen_drop", {63'd0, wback_reg_wen}, 64'd0);
    chk("op_rs1_reg", {32'd0, rs1_data}, 64'hDEADBEEF);

    // LUI to x0.
    drive(1, OP_LUI, 5'd0, 32'h12345000); rs2_addr = 5'd0;
    #1 chk("x0_rs2", {32'd0, rs2_data}, 64'd0);
    tick();
    drive(0, OP_OP, 5'd0, 32'd0);
    #1;
    chk("x0_wen", {63'd0, wback_reg_wen}, 64'd0);
    chk("x0_instret", instret_cnt, 64'd2);

    // STORE does not write rd.
    drive(1, OP_STORE, 5'd7, 32'h55); rs1_addr = 5'd7;
    tick();
    drive(0, OP_OP, 5'd0, 32'd0);
    #1;
    chk("st_wen", {63'd0, wback_reg_wen}, 64'd0);
    chk("st_rs1", {32'd0, rs1_data}, 64'd0);
    chk("st_instret", instret_cnt, 64'd3);
    tick();

    // Halt while a LOAD stream is presented.
    inst0 = instret_cnt;
    rs1_addr = 5'd9;
    halt_req = 1'b1;
    drive(1, OP_LOAD, 5'd9, 32'hA5);
    tick();
    drive(1, OP_LOAD, 5'd9, 32'hB6);
    #1;
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_ready", {63'd0, lsu_ready}, 64'd0);
    chk("halt_rs9", {32'd0, rs1_data}, 64'hA5);
    tick(); tick(); tick();
    halt_req = 1'b0;
    #1 chk("halt_wen", {63'd0, wback_reg_wen}, 64'd0);
    tick();
    #1 chk("resume_ready", {63'd0, lsu_ready}, 64'd1);
    tick();
    drive(0, OP_OP, 5'd0, 32'd0);
    #1;
    chk("resume_rs9", {32'd0, rs1_data}, 64'hB6);
    chk("resume_instret", instret_cnt - inst0, 64'd2);
    tick();

    // Reset wins over a simultaneous accept.
    drive(1, OP_OP, 5'd4, 32'h77);
    tick();
    drive(1, OP_OP, 5'd4, 32'd1); nrst = 1'b0; rs1_addr = 5'd4;
    tick();
    nrst = 1'b1; drive(0, OP_OP, 5'd0, 32'd0);
    #1;
    chk("rst_reg4", {32'd0, rs1_data}, 64'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, op_tbl[$urandom_range(0, 11)],
            5'($urandom_range(0, 7)), $urandom);
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      nrst = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
